jk_latch_driver: RTL and testbench
==================================

Name: jk_latch_driver

Overview:
- Upstream command stage for the jk_latch1 JK latch: accepts set/reset/toggle/hold commands over a valid/ready handshake, buffers them in a small FIFO, and drives the latch's j, k, en pins with controlled setup, enable-pulse and hold timing.
- Keeps a reference model of the expected latch state and compares it against the latch's q fed back into the block; any disagreement raises a sticky mismatch flag.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2).
- EN_CYCLES, 2, cycles en is held high per command (>=1).
- GAP_CYCLES, 1, cycles j/k are held after en falls (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_op  in  2  {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
- j  out  1  registered latch J.
- k  out  1  registered latch K.
- en  out  1  registered latch enable.
- q_in  in  1  latch q feedback.
- q_model  out  1  expected latch state.
- model_valid  out  1  q_model is known (after first set or reset).
- mismatch  out  1  sticky compare-failure flag.
- busy  out  1  FSM not IDLE or FIFO not empty.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): j=k=en=0, q_model=0, model_valid=0, mismatch=0, FIFO flushed (level=0), state=IDLE, cmd_ready=1 once reset releases. Asserting reset mid-command drops en immediately and discards all queued commands.
- Push: cmd_op is written when cmd_valid && cmd_ready at a rising edge. cmd_ready depends only on full, never on a same-cycle pop. A push and a pop in the same cycle leave level unchanged.
- FSM states IDLE, SETUP, PULSE, RECOVER:
  - IDLE: j=k=en=0. If FIFO is non-empty at the edge, pop the head, load j,k from cmd_op, go to SETUP.
  - SETUP (1 cycle): j/k valid, en=0. Go to PULSE.
  - PULSE (EN_CYCLES cycles): en=1, j/k stable. On entry, update the model:
    - 01: q_model=0, model_valid=1.
    - 10: q_model=1, model_valid=1.
    - 11: q_model=~q_model.
    - 00: q_model unchanged.
  - RECOVER (GAP_CYCLES cycles): en=0, j/k still held. At the last RECOVER edge, sample q_in. If model_valid && q_in != q_model, set mismatch=1. Go to IDLE.
- Latency: a command pushed into an empty FIFO at edge 0 has j/k visible after edge 1 and en high after edge 2 for EN_CYCLES cycles. Each command occupies 2+EN_CYCLES+GAP_CYCLES cycles, i.e. 5 with defaults.
- Toggle: the model toggles exactly once per command regardless of EN_CYCLES, because j/k are constant while en is high.
- Hold or toggle before model_valid: no comparison is made and mismatch cannot set. A toggle still inverts q_model.
- mismatch clears only on reset.
- Full FIFO: cmd_ready=0 and offered commands are not accepted. The source holds cmd_valid/cmd_op until accepted.
- Empty FIFO in IDLE: remain in IDLE, busy=0.
- Pointers wrap modulo DEPTH. level saturates correctly at DEPTH and 0.

Test Plan:
- Reset then single push cmd_op=10 at edge 0, latch connected: j=1,k=0 after edge 1; en=1 for 2 cycles from edge 2; q_model=1, model_valid=1, mismatch=0; busy=0 after 5 cycles.
- Push 01,11,11,10 back-to-back: all four accepted (level peaks ≤4); q_model sequence 0,1,0,1; en pulses separated by ≥3 low cycles; mismatch=0.
- Fill FIFO: hold cmd_valid=1 with pushes while FSM stalled on first command: cmd_ready=0 when level=4; the extra command is accepted only after the next pop; no command lost or duplicated.
- Fault injection: force q_in=0 during push 10: mismatch=1 at end of RECOVER and stays 1 through subsequent correct commands until rst_n=0.
- Toggle before model_valid: push 11 after reset with q_in=X/1: q_model=1, model_valid=0, mismatch stays 0.
- Reset mid-PULSE with 3 queued: en drops to 0 asynchronously; level=0, q_model=0, model_valid=0; after release no residual commands execute.

Source files
------------

// File: rtl/jk_latch_driver.sv
// jk_latch_driver: queues JK latch commands and drives j/k/en with
// setup, enable-pulse and hold timing; checks the latch q against a model.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cmd_valid/ready   command handshake (ready = FIFO not full)
//   cmd_op            {j,k}: 00 hold, 01 reset, 10 set, 11 toggle
//   j, k, en          registered latch drive
//   q_in              latch q feedback
//   q_model           expected latch state
//   model_valid       q_model known (after first set/reset)
//   mismatch          sticky compare failure
//   busy              FSM active or FIFO non-empty
//   level             FIFO occupancy
module jk_latch_driver #(
  parameter int DEPTH      = 4,
  parameter int EN_CYCLES  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  output logic                       j,
  output logic                       k,
  output logic                       en,
  input  logic                       q_in,
  output logic                       q_model,
  output logic                       model_valid,
  output logic                       mismatch,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH+1);
  localparam int MAXC = (EN_CYCLES > GAP_CYCLES) ?
                        EN_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    RECOVER
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full      = (level == LW'(DEPTH));
  assign empty     = (level == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == IDLE) & ~empty;
  assign busy      = (state != IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cmd_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Model update happens once on the SETUP->PULSE edge, so a toggle
  // flips q_model exactly once however long en stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      j           <= 1'b0;
      k           <= 1'b0;
      en          <= 1'b0;
      q_model     <= 1'b0;
      model_valid <= 1'b0;
      mismatch    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          en <= 1'b0;
          if (pop) begin
            j     <= mem[rd_ptr][1];
            k     <= mem[rd_ptr][0];
            state <= SETUP;
          end else begin
            j <= 1'b0;
            k <= 1'b0;
          end
        end
        SETUP: begin
          en    <= 1'b1;
          cnt   <= CW'(EN_CYCLES - 1);
          state <= PULSE;
          unique case ({j, k})
            2'b01: begin
              q_model     <= 1'b0;
              model_valid <= 1'b1;
            end
            2'b10: begin
              q_model     <= 1'b1;
              model_valid <= 1'b1;
            end
            2'b11:   q_model <= ~q_model;
            default: q_model <= q_model;
          endcase
        end
        PULSE: begin
          if (cnt == '0) begin
            en    <= 1'b0;
            cnt   <= CW'(GAP_CYCLES - 1);
            state <= RECOVER;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RECOVER: begin
          if (cnt == '0) begin
            if (model_valid && (q_in != q_model))
              mismatch <= 1'b1;
            j     <= 1'b0;
            k     <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_latch_driver.sv
// tb_jk_latch_driver: directed vectors and sequences for jk_latch_driver
// with a behavioural JK latch closing the q feedback loop.
module tb_jk_latch_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic       j, k, en;
  logic       q_in;
  logic       q_model, model_valid, mismatch, busy;
  logic [2:0] level;

  logic       q_lat = 1'b0;
  logic       force_en = 1'b0;
  logic       force_v = 1'b0;

  int errors = 0;
  int checks = 0;

  int pulses = 0;
  int gap = 100;
  logic en_prev = 1'b0;
  logic qseq [64];
  int   gapb [64];

  always #5 clk = ~clk;

  assign q_in = force_en ? force_v : q_lat;

  jk_latch_driver dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .j(j), .k(k), .en(en),
    .q_in(q_in), .q_model(q_model),
    .model_valid(model_valid), .mismatch(mismatch),
    .busy(busy), .level(level)
  );

  always @(posedge en) begin
    case ({j, k})
      2'b01:   q_lat <= 1'b0;
      2'b10:   q_lat <= 1'b1;
      2'b11:   q_lat <= ~q_lat;
      default: q_lat <= q_lat;
    endcase
  end

  always @(negedge clk) begin
    if (en && !en_prev) begin
      if (pulses < 64) begin
        qseq[pulses] <= q_model;
        gapb[pulses] <= gap;
      end
      pulses <= pulses + 1;
      gap    <= 0;
    end else if (!en) begin
      gap <= gap + 1;
    end
    en_prev <= en;
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [1:0] op);
    int t;
    t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200)
      chk("push_timeout", 1, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100)
      chk("idle_timeout", 1, 0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic       qm;
    logic       mv;
    logic       mm;
  } vec_t;

  vec_t tbl [6];
  logic exp_b2b  [4];
  logic exp_fill [6];
  logic [1:0] ops_b2b  [4];
  logic [1:0] ops_fill [6];

  initial begin
    int base;
    int t;
    logic saw_full;

    tbl[0] = '{2'b01, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{2'b11, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{2'b10, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{2'b00, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{2'b01, 1'b0, 1'b1, 1'b0};
    ops_b2b  = '{2'b01, 2'b11, 2'b11, 2'b10};
    exp_b2b  = '{1'b0, 1'b1, 1'b0, 1'b1};
    ops_fill = '{2'b10, 2'b01, 2'b11,
                 2'b11, 2'b01, 2'b10};
    exp_fill = '{1'b1, 1'b0, 1'b1,
                 1'b0, 1'b0, 1'b1};

    do_reset();
    @(negedge clk);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_en", en, 0);
    chk("rst_qm", q_model, 0);
    chk("rst_mv", model_valid, 0);
    chk("rst_mm", mismatch, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);

    // toggle before the model is known
    force_en = 1'b1;
    force_v  = 1'b1;
    push(2'b11);
    wait_idle();
    chk("tog_qm", q_model, 1);
    chk("tog_mv", model_valid, 0);
    chk("tog_mm", mismatch, 0);
    force_en = 1'b0;

    // single set: cycle-exact timing
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("e1_j", j, 1);
    chk("e1_k", k, 0);
    chk("e1_en", en, 0);
    @(posedge clk); #1;
    chk("e2_en", en, 1);
    chk("e2_qm", q_model, 1);
    @(posedge clk); #1;
    chk("e3_en", en, 1);
    @(posedge clk); #1;
    chk("e4_en", en, 0);
    chk("e4_j", j, 1);
    chk("e4_busy", busy, 1);
    @(posedge clk); #1;
    chk("e5_busy", busy, 0);
    chk("e5_j", j, 0);
    chk("e5_qm", q_model, 1);
    chk("e5_mv", model_valid, 1);
    chk("e5_mm", mismatch, 0);

    // table of single commands
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].op);
      wait_idle();
      chk($sformatf("tbl%0d_qm", i), q_model, tbl[i].qm);
      chk($sformatf("tbl%0d_mv", i), model_valid, tbl[i].mv);
      chk($sformatf("tbl%0d_mm", i), mismatch, tbl[i].mm);
    end

    // back-to-back
    base = pulses;
    for (int i = 0; i < 4; i++)
      push(ops_b2b[i]);
    wait_idle();
    chk("b2b_pulses", pulses - base, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_q%0d", i), qseq[base+i], exp_b2b[i]);
    for (int i = 1; i < 4; i++)
      chk($sformatf("b2b_gap%0d", i), gapb[base+i] >= 3, 1);
    chk("b2b_mm", mismatch, 0);

    // fill FIFO while the FSM is busy
    base = pulses;
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      t = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = ops_fill[i];
      while (!cmd_ready && t < 200) begin
        if (level == 3'd4)
          saw_full = 1'b1;
        @(negedge clk);
        t++;
      end
      if (t >= 200)
        chk("fill_timeout", 1, 0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
    chk("fill_saw_full", saw_full, 1);
    wait_idle();
    chk("fill_pulses", pulses - base, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("fill_q%0d", i), qseq[base+i], exp_fill[i]);
    chk("fill_level", level, 0);
    chk("fill_mm", mismatch, 0);

    // fault injection: latch stuck low during a set
    force_en = 1'b1;
    force_v  = 1'b0;
    push(2'b10);
    wait_idle();
    chk("flt_mm", mismatch, 1);
    force_en = 1'b0;
    push(2'b01);
    wait_idle();
    push(2'b10);
    wait_idle();
    chk("flt_sticky", mismatch, 1);
    chk("flt_qm", q_model, 1);

    // reset in the middle of a pulse with three queued
    do_reset();
    push(2'b10);
    push(2'b01);
    push(2'b11);
    push(2'b10);
    chk("mid_en_pre", en, 1);
    chk("mid_lvl_pre", level, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_en", en, 0);
    chk("mid_level", level, 0);
    chk("mid_qm", q_model, 0);
    chk("mid_mv", model_valid, 0);
    chk("mid_mm", mismatch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = pulses;
    repeat (20) @(negedge clk);
    chk("mid_no_resid", pulses - base, 0);
    chk("mid_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
